frame_wr_interface: RTL
=======================

// Module: frame_wr_interface
// PURPOSE
// - mem_clk-side DDR write master for incoming camera frames. Upstream of algo_rd_interface.
// - Drains 64-bit packed pixel words (8 px x 8 bit) from a FWFT async FIFO filled in the vin_clk domain.
// - Writes each frame line by line into DDR, in bursts, into a rotating set of frame buffers.
// - Publishes the index of the last complete frame (rd_frame_addr), which feeds the read side's frame_addr.
// PARAMETERS
// - BURST_LEN    128  max 64-bit words per DDR write burst
// - LINE_WORDS   160  64-bit words per video line (1280 px / 8)
// - FRAME_LINES  720  lines per complete frame
// - NUM_FRAMES   3    buffers in rotation (2..4); index is 2 bits
// PORTS
// - mem_clk            in   1   DDR user clock
// - rst_n              in   1   asynchronous, active-low reset
// - vin_vs             in   1   camera vsync, async to mem_clk, rising edge = frame start
// - fifo_dout          in   64  FWFT pixel FIFO head word
// - fifo_rd_count      in   9   words available in pixel FIFO (mem_clk domain)
// - fifo_rd_en         out  1   pop pixel FIFO
// - fifo_flush         out  1   1-cycle pulse: discard FIFO contents (dropped frame)
// - wr_burst_req       out  1   DDR write burst request
// - wr_burst_len       out  10  words in current burst
// - wr_burst_addr      out  27  byte address of current burst
// - wr_burst_data_req  in   1   DDR ctrl consumes wr_burst_data this cycle
// - wr_burst_data      out  64  burst data (= fifo_dout)
// - burst_finish       in   1   DDR ctrl: burst complete
// - rd_frame_addr      out  2   last fully written frame
// - frame_done         out  1   1-cycle pulse on rd_frame_addr update
// - drop_cnt           out  8   saturating count of incomplete frames
// BEHAVIOUR
// - Reset: all outputs 0. FSM in IDLE. wr_frame=0, line_cnt=0, word_cnt=0.
// - vin_vs: 2-FF sync plus edge detect gives frame_flag (1 cycle, 3 cycles after the edge).
// - FSM states:
//   - IDLE: go to WAIT_DATA when line_cnt<FRAME_LINES.
//   - WAIT_DATA: need = min(BURST_LEN, LINE_WORDS-word_cnt). Go to BURST_START when fifo_rd_count>=need.
//   - BURST_START: latch wr_burst_len=need; wr_burst_addr={1'b1,2'b0,wr_frame,line_cnt[10:0],word_cnt[7:0],3'b0}; set wr_burst_req. Go to BURSTING.
//   - BURSTING: wr_burst_req drops on the first wr_burst_data_req or on burst_finish. fifo_rd_en=wr_burst_data_req. On burst_finish, word_cnt+=wr_burst_len; go to BURST_END.
//   - BURST_END: if word_cnt==LINE_WORDS, go to LINE_END; else go to WAIT_DATA.
//   - LINE_END: word_cnt=0; line_cnt+=1; go to IDLE.
// - Frame completion: line_cnt reaching FRAME_LINES in LINE_END sets rd_frame_addr=wr_frame and pulses frame_done the next cycle. The FSM then idles until frame_flag.
// - frame_flag handling:
//   - Outside BURSTING/BURST_END it is applied immediately.
//   - In BURSTING it is latched (pend) and applied in the cycle after burst_finish. The DDR burst is never aborted.
//   - Apply: wr_frame = (wr_frame+1 == NUM_FRAMES) ? 0 : wr_frame+1; line_cnt=0; word_cnt=0; FSM to IDLE.
//   - If line_cnt!=FRAME_LINES at apply: the frame is dropped. rd_frame_addr is held, drop_cnt+=1 (saturating at 255), fifo_flush pulses, and wr_frame does NOT advance (buffer reused).
// - A frame_flag arriving during a pending apply is merged (single apply).
// - fifo_rd_en is never asserted outside BURSTING. A data_req with an empty FIFO is a protocol error and is not guarded.
// - wr_burst_data is combinational from fifo_dout (zero latency, FWFT).
// - Address arithmetic: 11-bit line, 11-bit byte column; no carry between fields.
// STRUCTURE
// - Shared package: burst state encodings, DDR address field widths, FRAME_IDX_W=2.
// - Sub-module vs_sync_edge (2-FF sync + rising-edge pulse). Reusable for the read side's frame_flag.
// - Everything else stays in one FSM file.
// TESTING
// - Use LINE_WORDS=160, FRAME_LINES=4, FIFO model that always has data.
//   - Per line: bursts len 128 @ col 0, then len 32 @ byte col 1024.
//   - Line 2 addr = {1,00,frame,11'd2,11'd0}.
// - Full frame, then vin_vs: frame_done pulses once; rd_frame_addr=0; next frame writes frame 1; third rolls to 2, then 0.
// - fifo_rd_count=100 for 50 cycles: stay in WAIT_DATA with no req. Raise to 128: burst issued within 2 cycles.
// - vin_vs mid-burst (line 1): burst completes with exactly 128 data_req. Then drop_cnt=1, fifo_flush pulse, wr_frame unchanged, rd_frame_addr unchanged.
// - 256 consecutive dropped frames: drop_cnt saturates at 255.
// - rst_n asserted mid-BURSTING: all outputs 0 immediately. After release the FSM waits for line data from IDLE at frame 0.

Source files
------------

// File: rtl/frame_wr_interface_pkg.sv
// Shared definitions for the frame write master: burst FSM states, DDR address layout, bus widths.
package frame_wr_interface_pkg;

  localparam int DATA_W      = 64;
  localparam int FIFO_CNT_W  = 9;
  localparam int BURST_LEN_W = 10;
  localparam int ADDR_W      = 27;
  localparam int FRAME_IDX_W = 2;
  localparam int DROP_W      = 8;

  // DDR byte address: {1, 2'b00, frame, line, byte column}
  localparam int LINE_FIELD_W = 11;
  localparam int COL_FIELD_W  = 11;
  localparam int WORD_IDX_W   = COL_FIELD_W - 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_DATA   = 3'd1,
    ST_BURST_START = 3'd2,
    ST_BURSTING    = 3'd3,
    ST_BURST_END   = 3'd4,
    ST_LINE_END    = 3'd5
  } burst_state_t;

  function automatic logic [ADDR_W-1:0] make_burst_addr(
    input logic [FRAME_IDX_W-1:0]  frame,
    input logic [LINE_FIELD_W-1:0] line,
    input logic [WORD_IDX_W-1:0]   word
  );
    return {1'b1, 2'b00, frame, line, word, 3'b000};
  endfunction

endpackage

// File: rtl/vs_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector; one-cycle pulse three
// mem_clk edges after the input rises. No backpressure.
module vs_sync_edge (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], async_in};
      rise_pulse <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/frame_wr_interface.sv
// Drains the FWFT pixel FIFO into DDR line by line in bursts across rotating frame buffers.
// Data path is zero-latency (fifo_rd_en follows wr_burst_data_req); a burst only starts once the FIFO holds it.
module frame_wr_interface
  import frame_wr_interface_pkg::*;
#(
  parameter int BURST_LEN   = 128,
  parameter int LINE_WORDS  = 160,
  parameter int FRAME_LINES = 720,
  parameter int NUM_FRAMES  = 3
) (
  input  logic                   mem_clk,
  input  logic                   rst_n,
  input  logic                   vin_vs,
  input  logic [DATA_W-1:0]      fifo_dout,
  input  logic [FIFO_CNT_W-1:0]  fifo_rd_count,
  output logic                   fifo_rd_en,
  output logic                   fifo_flush,
  output logic                   wr_burst_req,
  output logic [BURST_LEN_W-1:0] wr_burst_len,
  output logic [ADDR_W-1:0]      wr_burst_addr,
  input  logic                   wr_burst_data_req,
  output logic [DATA_W-1:0]      wr_burst_data,
  input  logic                   burst_finish,
  output logic [FRAME_IDX_W-1:0] rd_frame_addr,
  output logic                   frame_done,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam logic [BURST_LEN_W-1:0]  BURST_LEN_C   = BURST_LEN_W'(BURST_LEN);
  localparam logic [BURST_LEN_W-1:0]  LINE_WORDS_C  = BURST_LEN_W'(LINE_WORDS);
  localparam logic [LINE_FIELD_W-1:0] FRAME_LINES_C = LINE_FIELD_W'(FRAME_LINES);
  localparam logic [FRAME_IDX_W-1:0]  LAST_FRAME    = FRAME_IDX_W'(NUM_FRAMES - 1);

  burst_state_t            state;
  logic [FRAME_IDX_W-1:0]  wr_frame;
  logic [LINE_FIELD_W-1:0] line_cnt;
  logic [BURST_LEN_W-1:0]  word_cnt;
  logic                    pend;
  logic                    frame_flag;
  logic [BURST_LEN_W-1:0]  remain;
  logic [BURST_LEN_W-1:0]  need;
  logic                    apply;
  logic                    frame_complete;

  vs_sync_edge u_vs_sync (
    .mem_clk    (mem_clk),
    .rst_n      (rst_n),
    .async_in   (vin_vs),
    .rise_pulse (frame_flag)
  );

  always_comb begin
    remain = LINE_WORDS_C - word_cnt;
    need   = (remain > BURST_LEN_C) ? BURST_LEN_C : remain;
  end

  // A running DDR burst is never cut short: a frame start seen mid-burst waits
  // in pend and takes effect in BURST_END.
  assign apply          = (state != ST_BURSTING) && (frame_flag || pend);
  assign frame_complete = (line_cnt == FRAME_LINES_C);

  assign fifo_rd_en    = (state == ST_BURSTING) && wr_burst_data_req;
  assign wr_burst_data = (state == ST_BURSTING) ? fifo_dout : '0;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wr_frame      <= '0;
      line_cnt      <= '0;
      word_cnt      <= '0;
      pend          <= 1'b0;
      fifo_flush    <= 1'b0;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      rd_frame_addr <= '0;
      frame_done    <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      fifo_flush <= 1'b0;
      if (apply) begin
        state        <= ST_IDLE;
        line_cnt     <= '0;
        word_cnt     <= '0;
        pend         <= 1'b0;
        wr_burst_req <= 1'b0;
        if (frame_complete) begin
          wr_frame <= (wr_frame == LAST_FRAME) ? '0 : wr_frame + FRAME_IDX_W'(1);
        end else begin
          // Partial frame: rewrite the same buffer and throw away stale pixels.
          fifo_flush <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (line_cnt < FRAME_LINES_C) state <= ST_WAIT_DATA;
          end
          ST_WAIT_DATA: begin
            if ({1'b0, fifo_rd_count} >= need) state <= ST_BURST_START;
          end
          ST_BURST_START: begin
            wr_burst_len  <= need;
            wr_burst_addr <= make_burst_addr(wr_frame, line_cnt, word_cnt[WORD_IDX_W-1:0]);
            wr_burst_req  <= 1'b1;
            state         <= ST_BURSTING;
          end
          ST_BURSTING: begin
            if (frame_flag) pend <= 1'b1;
            if (wr_burst_data_req || burst_finish) wr_burst_req <= 1'b0;
            if (burst_finish) begin
              word_cnt <= word_cnt + wr_burst_len;
              state    <= ST_BURST_END;
            end
          end
          ST_BURST_END: begin
            state <= (word_cnt == LINE_WORDS_C) ? ST_LINE_END : ST_WAIT_DATA;
          end
          ST_LINE_END: begin
            word_cnt <= '0;
            line_cnt <= line_cnt + LINE_FIELD_W'(1);
            if (line_cnt + LINE_FIELD_W'(1) == FRAME_LINES_C) begin
              rd_frame_addr <= wr_frame;
              frame_done    <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
